// File: rtl/sprite_palette_encoder_pkg.sv
// sprite_palette_encoder_pkg: shared types and constants for the RGB-to-palette-index encoder.
package sprite_palette_encoder_pkg;
    localparam int PAL_DEPTH = 16;
    localparam int CH_W = 4;
    typedef logic [3*CH_W-1:0] rgb_t;
    typedef logic [$clog2(PAL_DEPTH)-1:0] pal_idx_t;
    typedef logic [5:0] dist_t;
    typedef enum logic [1:0] {IDLE, SEARCH, DONE} enc_state_t;
endpackage

// File: rtl/sprite_palette_encoder_distance.sv
// rgb_l1_distance: combinational Manhattan distance between two {r,g,b} colours.
module rgb_l1_distance
    import sprite_palette_encoder_pkg::*;
(
    input  rgb_t  a,
    input  rgb_t  b,
    output dist_t d
);
    logic [CH_W-1:0] dr, dg, db;
    always_comb begin
        dr = (a[11:8] > b[11:8]) ? a[11:8] - b[11:8] : b[11:8] - a[11:8];
        dg = (a[7:4] > b[7:4]) ? a[7:4] - b[7:4] : b[7:4] - a[7:4];
        db = (a[3:0] > b[3:0]) ? a[3:0] - b[3:0] : b[3:0] - a[3:0];
        d = dist_t'(dr) + dist_t'(dg) + dist_t'(db);
    end
endmodule

// File: rtl/sprite_palette_encoder.sv
// sprite_palette_encoder: finds the nearest palette entry to an RGB pixel, one entry per cycle.
module sprite_palette_encoder #(
    parameter int PAL_DEPTH = 16,
    parameter int CH_W = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         pal_we,
    input  logic [$clog2(PAL_DEPTH)-1:0] pal_addr,
    input  logic [3*CH_W-1:0]            pal_data,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [3*CH_W-1:0]            in_rgb,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [$clog2(PAL_DEPTH)-1:0] out_index,
    output logic                         out_exact,
    output logic                         busy
);
    import sprite_palette_encoder_pkg::*;
    localparam pal_idx_t LAST = pal_idx_t'(PAL_DEPTH - 1);
    enc_state_t state, state_nxt;
    rgb_t pal [PAL_DEPTH];
    rgb_t pix;
    pal_idx_t k, idx;
    dist_t d, best;
    logic fin;
    rgb_l1_distance u_dist (.a(pix), .b(pal[k]), .d(d));
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else state <= state_nxt;
    end
    always_comb begin
        state_nxt = state;
        state_nxt = (state == IDLE && in_valid) ? SEARCH :
                    (state == SEARCH && fin) ? DONE :
                    (state == DONE && out_ready) ? IDLE : state;
    end
    // fin marks the last compared entry; DONE follows one cycle later
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < PAL_DEPTH; i++) pal[i] <= '0;
            pix <= '0;
            k <= '0;
            idx <= '0;
            best <= '1;
            fin <= 1'b0;
        end else begin
            if (pal_we && state == IDLE) pal[pal_addr] <= pal_data;
            if (state == IDLE && in_valid) begin
                pix <= in_rgb;
                k <= '0;
                idx <= '0;
                best <= '1;
                fin <= 1'b0;
            end else if (state == SEARCH && !fin) begin
                if (d < best) begin
                    best <= d;
                    idx <= k;
                end
                if (d == '0 || k == LAST) fin <= 1'b1;
                else k <= k + 1'b1;
            end
        end
    end
    assign in_ready = state == IDLE;
    assign busy = state != IDLE;
    assign out_valid = state == DONE;
    assign out_index = idx;
    assign out_exact = best == '0;
endmodule

// File: tb/tb_sprite_palette_encoder.sv
// tb_sprite_palette_encoder: directed vectors against hand-computed nearest-entry results.
module tb_sprite_palette_encoder;
    logic clk = 1'b0, reset = 1'b1, pal_we = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic [3:0] pal_addr = '0;
    logic [11:0] pal_data = '0, in_rgb = '0;
    logic in_ready, out_valid, out_exact, busy;
    logic [3:0] out_index;
    int total = 0, bad = 0;

    sprite_palette_encoder dut (
        .clk(clk), .reset(reset), .pal_we(pal_we), .pal_addr(pal_addr), .pal_data(pal_data),
        .in_valid(in_valid), .in_ready(in_ready), .in_rgb(in_rgb), .out_valid(out_valid),
        .out_ready(out_ready), .out_index(out_index), .out_exact(out_exact), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [3:0] a, input logic [11:0] v);
        pal_we = 1'b1; pal_addr = a; pal_data = v;
        tick;
        pal_we = 1'b0;
    endtask

    task automatic encode(input string tag, input logic [11:0] rgb, input logic [3:0] eidx,
                          input logic eex, input int elat, input int hold, input logic drop_we);
        int n = 0;
        check({tag, "_in_ready"}, in_ready, 1);
        in_valid = 1'b1; in_rgb = rgb;
        tick;
        in_valid = 1'b0; pal_we = 1'b0;
        if (drop_we) begin
            pal_we = 1'b1; pal_addr = 4'd2; pal_data = 12'h123;
        end
        while (!out_valid && n < 40) begin
            tick;
            n++;
        end
        pal_we = 1'b0;
        check({tag, "_lat"}, n, elat);
        check({tag, "_idx"}, out_index, eidx);
        check({tag, "_exact"}, out_exact, eex);
        for (int h = 0; h < hold; h++) begin
            tick;
            check({tag, "_hold_valid"}, out_valid, 1);
            check({tag, "_hold_idx"}, out_index, eidx);
            check({tag, "_hold_exact"}, out_exact, eex);
            check({tag, "_hold_ready"}, in_ready, 0);
        end
        out_ready = 1'b1;
        tick;
        out_ready = 1'b0;
        check({tag, "_idle_valid"}, out_valid, 0);
        check({tag, "_idle_ready"}, in_ready, 1);
    endtask

    initial begin
        logic seen;
        tick; tick;
        reset = 1'b0;
        tick;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_index", out_index, 0);
        check("rst_out_exact", out_exact, 0);
        check("rst_busy", busy, 0);
        wr(4'd0, 12'h00A); wr(4'd1, 12'hAEA); wr(4'd2, 12'hFFF); wr(4'd3, 12'hB0B); wr(4'd4, 12'hF76);
        for (int i = 5; i < 16; i++) wr(4'(i), 12'hAEA);
        encode("fff", 12'hFFF, 4'd2, 1'b1, 4, 0, 1'b0);
        encode("aea", 12'hAEA, 4'd1, 1'b1, 3, 0, 1'b0);
        encode("f86", 12'hF86, 4'd4, 1'b0, 17, 0, 1'b0);
        encode("zero", 12'h000, 4'd0, 1'b0, 17, 0, 1'b0);
        encode("stall", 12'hFFF, 4'd2, 1'b1, 4, 5, 1'b0);
        encode("drop", 12'hFFF, 4'd2, 1'b1, 4, 0, 1'b1);
        encode("after_drop", 12'hFFF, 4'd2, 1'b1, 4, 0, 1'b0);
        pal_we = 1'b1; pal_addr = 4'd5; pal_data = 12'h123;
        encode("wr_accept", 12'h123, 4'd5, 1'b1, 7, 0, 1'b0);
        wr(4'd5, 12'hAEA);
        in_valid = 1'b1; in_rgb = 12'h555;
        tick;
        in_valid = 1'b0;
        for (int i = 0; i < 8; i++) tick;
        check("mid_busy", busy, 1);
        reset = 1'b1;
        tick;
        reset = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            seen |= out_valid;
            tick;
        end
        check("abort_no_valid", seen, 0);
        check("abort_in_ready", in_ready, 1);
        encode("cleared", 12'h555, 4'd0, 1'b0, 17, 0, 1'b0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
